div_cfg_ctrl: RTL and testbench

Run/stop and ratio-configuration controller for the team's counter-based clock divider. Accepts a new half-period count through a valid/ready handshake and applies it only at a clean boundary, the falling edge of the divided clock, so clk_out never shows a runt pulse. Starts and stops the divided clock glitch-free under an enable input. Sits between the register/config logic and every consumer of the divided clock or its rise strobe.

---
 rtl/div_cfg_ctrl.sv | 127 ++++++++++++
 tb/tb_div_cfg_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_cfg_ctrl.sv
// rtl/div_cfg_ctrl.sv - run/stop and glitch-free ratio update controller for the counter clock divider
module div_cfg_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             clk_out_rise,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] div_reg, div_nxt;
    logic [CNT_W-1:0] pend_div, pend_div_nxt;
    logic             pend, pend_nxt;
    logic             clk_nxt, rise_nxt, err_nxt;
    logic             end_cnt, accept, apply;

    assign cfg_ready = !pend;
    assign busy      = (state != IDLE);
    assign accept    = cfg_valid && !pend;
    assign end_cnt   = (cnt == div_reg - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            div_reg      <= CNT_W'(DIV_DEFAULT);
            pend_div     <= '0;
            pend         <= 1'b0;
            clk_out      <= 1'b0;
            clk_out_rise <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            div_reg      <= div_nxt;
            pend_div     <= pend_div_nxt;
            pend         <= pend_nxt;
            clk_out      <= clk_nxt;
            clk_out_rise <= rise_nxt;
            cfg_err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        div_nxt      = div_reg;
        pend_div_nxt = pend_div;
        pend_nxt     = pend;
        clk_nxt      = clk_out;
        apply        = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                clk_nxt = 1'b0;
                apply   = pend;
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!en && !clk_out) begin
                    // Output already low: stopping here cannot shorten a high pulse.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (end_cnt) begin
                    cnt_nxt = '0;
                    clk_nxt = !clk_out;
                    if (clk_out) begin
                        apply = pend;
                        if (!en) begin
                            state_nxt = IDLE;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (!en) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                // Finish the high half at full length before parking low.
                if (end_cnt) begin
                    cnt_nxt   = '0;
                    clk_nxt   = 1'b0;
                    apply     = pend;
                    state_nxt = en ? RUN : IDLE;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                    state_nxt = en ? RUN : STOP;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                clk_nxt   = 1'b0;
            end
        endcase

        if (apply) begin
            div_nxt  = pend_div;
            pend_nxt = 1'b0;
        end
        // Accept only happens with pend clear, so it never collides with apply.
        if (accept && (cfg_div != '0)) begin
            pend_div_nxt = cfg_div;
            pend_nxt     = 1'b1;
        end

        err_nxt  = accept && (cfg_div == '0);
        rise_nxt = clk_nxt && !clk_out;
    end

endmodule

// File: tb/tb_div_cfg_ctrl.sv
// tb/tb_div_cfg_ctrl.sv - self-checking bench for div_cfg_ctrl
module tb_div_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       clk_out;
    logic       clk_out_rise;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    div_cfg_ctrl #(.CNT_W(8), .DIV_DEFAULT(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_div      (cfg_div),
        .cfg_ready    (cfg_ready),
        .cfg_err      (cfg_err),
        .clk_out      (clk_out),
        .clk_out_rise (clk_out_rise),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles until clk_out changes level, and rise strobes seen on the way.
    task automatic wait_change(output int n, output int rises);
        logic v;
        v     = clk_out;
        n     = 0;
        rises = 0;
        do begin
            tick();
            n++;
            if (clk_out_rise === 1'b1) rises++;
        end while (clk_out === v && n < 100);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        repeat (2) tick();
        total++; if (clk_out !== 1'b0)      begin bad++; $display("FAIL rst_clk_out: got %0b want 0", clk_out); end
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        total++; if (cfg_ready !== 1'b1)    begin bad++; $display("FAIL rst_cfg_ready: got %0b want 1", cfg_ready); end
        total++; if (cfg_err !== 1'b0)      begin bad++; $display("FAIL rst_cfg_err: got %0b want 0", cfg_err); end
        total++; if (clk_out_rise !== 1'b0) begin bad++; $display("FAIL rst_rise: got %0b want 0", clk_out_rise); end
        rst_n = 1'b1;
        tick();
        total++; if (busy !== 1'b0 || clk_out !== 1'b0) begin bad++; $display("FAIL rst_release_idle: got busy=%0b clk_out=%0b want 0/0", busy, clk_out); end
    endtask

    task automatic test_start();
        int e, n, r;
        en = 1'b1;
        tick();
        total++; if (busy !== 1'b1)    begin bad++; $display("FAIL start_busy: got %0b want 1", busy); end
        total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL start_clk_low: got %0b want 0", clk_out); end
        exp_q = '{5, 5, 5, 5, 5};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_change(n, r);
            total++; if (n !== e) begin bad++; $display("FAIL start_half: got %0d cycles want %0d", n, e); end
            total++; if (r !== int'(clk_out)) begin bad++; $display("FAIL start_rise_count: got %0d want %0d", r, int'(clk_out)); end
        end
    endtask

    task automatic test_cfg_zero();
        int e, n, r;
        cfg_valid = 1'b1; cfg_div = 8'd0;
        tick();
        total++; if (cfg_err !== 1'b1)   begin bad++; $display("FAIL zero_err_pulse: got %0b want 1", cfg_err); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL zero_ready: got %0b want 1", cfg_ready); end
        cfg_valid = 1'b0;
        tick();
        total++; if (cfg_err !== 1'b0)   begin bad++; $display("FAIL zero_err_width: got %0b want 0", cfg_err); end
        exp_q = '{3, 5, 5, 5};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_change(n, r);
            total++; if (n !== e) begin bad++; $display("FAIL zero_half: got %0d cycles want %0d", n, e); end
        end
    endtask

    task automatic test_ratio_change();
        int e, n, r;
        repeat (2) tick();
        cfg_valid = 1'b1; cfg_div = 8'd3;
        tick();
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL chg_ready_low: got %0b want 0", cfg_ready); end
        cfg_valid = 1'b0;
        wait_change(n, r);
        total++; if (n !== 2) begin bad++; $display("FAIL chg_old_high: got %0d cycles want 2", n); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL chg_ready_at_fall: got %0b want 1", cfg_ready); end
        exp_q = '{3, 3, 3};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_change(n, r);
            total++; if (n !== e) begin bad++; $display("FAIL chg_half: got %0d cycles want %0d", n, e); end
        end
    endtask

    task automatic test_pend_hold();
        int e, n, r;
        cfg_valid = 1'b1; cfg_div = 8'd5;
        tick();
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL hold_first_accept: got %0b want 0", cfg_ready); end
        cfg_div = 8'd2;
        wait_change(n, r);
        total++; if (n !== 2) begin bad++; $display("FAIL hold_high3: got %0d cycles want 2", n); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL hold_ready_at_fall: got %0b want 1", cfg_ready); end
        tick();
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL hold_second_accept: got %0b want 0", cfg_ready); end
        cfg_valid = 1'b0;
        exp_q = '{4, 5, 2, 2, 2};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_change(n, r);
            total++; if (n !== e) begin bad++; $display("FAIL hold_half: got %0d cycles want %0d", n, e); end
        end
        cfg_valid = 1'b1; cfg_div = 8'd5;
        tick();
        cfg_valid = 1'b0;
        exp_q = '{1, 5};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_change(n, r);
            total++; if (n !== e) begin bad++; $display("FAIL restore_half: got %0d cycles want %0d", n, e); end
        end
    endtask

    task automatic test_stop_high();
        int n, r, glitches;
        tick();
        en = 1'b0;
        wait_change(n, r);
        total++; if (n !== 4) begin bad++; $display("FAIL stop_high_len: got %0d cycles want 4", n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_high_busy: got %0b want 0", busy); end
        glitches = 0;
        repeat (6) begin
            tick();
            if (clk_out !== 1'b0 || busy !== 1'b0) glitches++;
        end
        total++; if (glitches !== 0) begin bad++; $display("FAIL stop_high_parked: got %0d active cycles want 0", glitches); end
    endtask

    task automatic test_stop_low();
        int e, n, r, glitches;
        en = 1'b1;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy: got %0b want 1", busy); end
        exp_q = '{5, 5};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_change(n, r);
            total++; if (n !== e) begin bad++; $display("FAIL restart_half: got %0d cycles want %0d", n, e); end
        end
        tick();
        en = 1'b0;
        tick();
        total++; if (busy !== 1'b0 || clk_out !== 1'b0) begin bad++; $display("FAIL stop_low: got busy=%0b clk_out=%0b want 0/0", busy, clk_out); end
        glitches = 0;
        repeat (8) begin
            tick();
            if (clk_out !== 1'b0 || clk_out_rise !== 1'b0) glitches++;
        end
        total++; if (glitches !== 0) begin bad++; $display("FAIL stop_low_parked: got %0d active cycles want 0", glitches); end
    endtask

    task automatic test_reset_midrun();
        int n, r;
        en = 1'b1;
        tick();
        wait_change(n, r);
        total++; if (n !== 5) begin bad++; $display("FAIL mid_pre_rise: got %0d cycles want 5", n); end
        tick();
        cfg_valid = 1'b1; cfg_div = 8'd3;
        tick();
        cfg_valid = 1'b0;
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL mid_pending: got %0b want 0", cfg_ready); end
        #3 rst_n = 1'b0;
        #1;
        total++; if (clk_out !== 1'b0)      begin bad++; $display("FAIL mid_rst_clk_out: got %0b want 0", clk_out); end
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL mid_rst_busy: got %0b want 0", busy); end
        total++; if (cfg_ready !== 1'b1)    begin bad++; $display("FAIL mid_rst_ready: got %0b want 1", cfg_ready); end
        total++; if (clk_out_rise !== 1'b0 || cfg_err !== 1'b0) begin bad++; $display("FAIL mid_rst_strobes: got rise=%0b err=%0b want 0/0", clk_out_rise, cfg_err); end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_restart_busy: got %0b want 1", busy); end
        wait_change(n, r);
        total++; if (n !== 5) begin bad++; $display("FAIL mid_restart_latency: got %0d cycles want 5", n); end
        wait_change(n, r);
        total++; if (n !== 5) begin bad++; $display("FAIL mid_restart_high: got %0d cycles want 5", n); end
        en = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_start();
        test_cfg_zero();
        test_ratio_change();
        test_pend_hold();
        test_stop_high();
        test_stop_low();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
